// File: rtl/sd_writer_pkg.sv
// sd_writer_pkg: shared types and constants for the SD block writer.
package sd_writer_pkg;

    localparam int unsigned SD_BLOCK_BYTES = 512;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StIssue,
        StAccept,
        StXfer,
        StWaitDone,
        StFlushPad
    } sd_wr_state_t;

endpackage

// File: rtl/sd_write_fifo.sv
// sd_write_fifo: first-word-fall-through byte FIFO with occupancy count,
// async active-low reset and a synchronous clear.
import sd_writer_pkg::*;

module sd_write_fifo #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [7:0]             wdata_i,
    input  logic                   pop_i,
    output logic [7:0]             rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

    byte_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointers and occupancy; clr_i empties the FIFO without touching storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sd_block_writer.sv
// sd_block_writer: buffers producer bytes and writes them to sd_controller in
// BLOCK_BYTES blocks at consecutive addresses from START_ADDR.
// Optional: define SD_BLOCK_WRITER_PAD_EN to pad and write a partial final
// block with PAD_BYTE; without it a partial final block is discarded.
import sd_writer_pkg::*;

module sd_block_writer #(
    parameter logic [31:0] START_ADDR  = 32'h0,
    parameter int unsigned BLOCK_BYTES = SD_BLOCK_BYTES,
    parameter int unsigned FIFO_DEPTH  = 1024,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        stop_in,
    input  logic [7:0]  data_in,
    input  logic        data_valid_in,
    output logic        data_ready_out,
    input  logic        sd_ready_in,
    input  logic        sd_ready_for_next_byte_in,
    output logic        sd_wr_out,
    output logic [7:0]  sd_din_out,
    output logic [31:0] sd_addr_out,
    output logic        busy_out,
    output logic        done_out,
    output logic [15:0] blocks_written_out
);
    localparam int unsigned     CntW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] BlockCnt = CntW'(BLOCK_BYTES);
    localparam logic [9:0]      LastByte = 10'(BLOCK_BYTES - 1);
    localparam logic [31:0]     AddrStep = 32'(BLOCK_BYTES);

    sd_wr_state_t    state_q, state_d;
    logic [CntW-1:0] fifo_count;
    logic            fifo_full, fifo_empty, fifo_clr, fifo_push;
    byte_t           fifo_head;
    logic            busy, consume;
    logic            rfnb_q;
    logic            stop_q, stop_d;
    logic            pop_q, pop_d;
    logic            wr_q, wr_d;
    logic            done_q, done_d;
    logic [9:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [15:0]     blocks_q, blocks_d;

    sd_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_n_in),
        .clr_i   (fifo_clr),
        .push_i  (fifo_push),
        .wdata_i (data_in),
        .pop_i   (pop_q),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign busy    = (state_q != StIdle);
    assign consume = (state_q == StXfer) && sd_ready_for_next_byte_in && !rfnb_q;

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= StIdle;
        else           state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start_in) state_d = StFill;
            StFill: begin
                if (fifo_count >= BlockCnt) begin
                    state_d = StIssue;
                end else if (stop_q) begin
                    if (fifo_empty) state_d = StIdle;
`ifdef SD_BLOCK_WRITER_PAD_EN
                    else            state_d = StIssue;
`else
                    else            state_d = StFlushPad;
`endif
                end
            end
            StIssue:    if (sd_ready_in) state_d = StAccept;
            StAccept:   if (!sd_ready_in) state_d = StXfer;
            StXfer:     if (consume && byte_cnt_q == LastByte) state_d = StWaitDone;
            StWaitDone: if (sd_ready_in) state_d = StFill;
            StFlushPad: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs and FIFO controls; the consumed byte is popped one cycle late so
    // sd_din_out holds it through the cycle after the consume edge.
    always_comb begin
        busy_out           = busy;
        data_ready_out     = busy && !stop_q && !fifo_full;
        fifo_push          = data_valid_in && data_ready_out;
        fifo_clr           = ((state_q == StIdle) && start_in) || (state_q == StFlushPad);
        sd_din_out         = !fifo_empty ? fifo_head : (stop_q ? PAD_BYTE : 8'h00);
        sd_wr_out          = wr_q;
        sd_addr_out        = addr_q;
        done_out           = done_q;
        blocks_written_out = blocks_q;
    end

    // Next values for the datapath registers.
    always_comb begin
        stop_d = stop_q | stop_in;
        if (state_q == StIdle || state_d == StIdle) stop_d = 1'b0;
        wr_d   = (state_q == StIssue) && sd_ready_in;
        done_d = busy && (state_d == StIdle);
        pop_d  = consume;

        byte_cnt_d = byte_cnt_q;
        if (state_q == StIssue) byte_cnt_d = '0;
        else if (consume)       byte_cnt_d = byte_cnt_q + 10'd1;

        addr_d   = addr_q;
        blocks_d = blocks_q;
        if (state_q == StIdle && start_in) begin
            addr_d   = START_ADDR;
            blocks_d = '0;
        end else if (state_q == StWaitDone && sd_ready_in) begin
            addr_d   = addr_q + AddrStep;
            blocks_d = blocks_q + 16'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rfnb_q     <= 1'b0;
            stop_q     <= 1'b0;
            pop_q      <= 1'b0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            byte_cnt_q <= '0;
            addr_q     <= START_ADDR;
            blocks_q   <= '0;
        end else begin
            rfnb_q     <= sd_ready_for_next_byte_in;
            stop_q     <= stop_d;
            pop_q      <= pop_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            blocks_q   <= blocks_d;
        end
    end

endmodule

// File: tb/tb_sd_block_writer.sv
// Self-checking bench for sd_block_writer with a behavioural card model.
module tb_sd_block_writer;
    localparam int          BB    = 512;
    localparam int          DEPTH = 1024;
    localparam logic [7:0]  PAD   = 8'hA5;
    localparam logic [31:0] BASE  = 32'h0000_4000;

    logic        clk, rst_n, start, stop, data_valid, sd_ready, rfnb;
    logic [7:0]  data;
    logic        data_ready, sd_wr, busy, done;
    logic [7:0]  sd_din;
    logic [31:0] sd_addr;
    logic [15:0] blocks;

    sd_block_writer #(
        .START_ADDR  (BASE),
        .BLOCK_BYTES (BB),
        .FIFO_DEPTH  (DEPTH),
        .PAD_BYTE    (PAD)
    ) dut (
        .clk_in                    (clk),
        .rst_n_in                  (rst_n),
        .start_in                  (start),
        .stop_in                   (stop),
        .data_in                   (data),
        .data_valid_in             (data_valid),
        .data_ready_out            (data_ready),
        .sd_ready_in               (sd_ready),
        .sd_ready_for_next_byte_in (rfnb),
        .sd_wr_out                 (sd_wr),
        .sd_din_out                (sd_din),
        .sd_addr_out               (sd_addr),
        .busy_out                  (busy),
        .done_out                  (done),
        .blocks_written_out        (blocks)
    );

    int          n_checks = 0;
    int          n_err = 0;
    logic [7:0]  prod_q[$];
    logic [7:0]  sent_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  cap_q[$];
    logic [31:0] blk_addr_q[$];
    int          wr_cnt = 0, done_cnt = 0, wr_double = 0;
    int          acc_cnt = 0, cons_cnt = 0, stall_cnt = 0, stall_bad = 0;
    int          card_idx = -1, hold_at = -1, card_gap_max = 2;
    bit          prod_rand = 1'b1;
    logic [7:0]  hold_din = 8'h00;
    logic        wr_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Card: answers a wr pulse by dropping ready, requesting BB bytes, then raising ready.
    initial begin : card_model
        int gap;
        sd_ready = 1'b1;
        rfnb     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && sd_wr === 1'b1) begin
                wr_cnt++;
                blk_addr_q.push_back(sd_addr);
                sd_ready = 1'b0;
                repeat (2) @(negedge clk);
                for (int i = 0; i < BB; i++) begin
                    if (!rst_n) break;
                    rfnb = 1'b1;
                    cons_cnt++;
                    card_idx = i;
                    @(negedge clk);
                    cap_q.push_back(sd_din);
                    if (i == hold_at) begin
                        repeat (4) @(negedge clk);
                        hold_din = sd_din;
                    end
                    rfnb = 1'b0;
                    gap = $urandom_range(1, card_gap_max);
                    repeat (gap) @(negedge clk);
                end
                rfnb = 1'b0;
                repeat (2) @(negedge clk);
                sd_ready = 1'b1;
            end
        end
    end

    // Producer: offers queued bytes, dropping a byte only once it is taken.
    initial begin : producer
        data_valid = 1'b0;
        data       = 8'h00;
        forever begin
            @(negedge clk);
            if (prod_q.size() > 0 && rst_n && (!prod_rand || $urandom_range(0, 3) != 0)) begin
                data_valid = 1'b1;
                data       = prod_q[0];
                if (data_ready) begin
                    void'(prod_q.pop_front());
                    acc_cnt++;
                end else if (busy) begin
                    stall_cnt++;
                    if (acc_cnt - cons_cnt < DEPTH - 2) stall_bad++;
                end
            end else begin
                data_valid = 1'b0;
                data       = 8'($urandom);
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (sd_wr === 1'b1 && wr_prev === 1'b1) wr_double++;
            wr_prev = sd_wr;
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, " data_ready"}, 32'(data_ready), 32'd0);
        chk({tag, " sd_wr"}, 32'(sd_wr), 32'd0);
        chk({tag, " sd_din"}, 32'(sd_din), 32'd0);
        chk({tag, " sd_addr"}, sd_addr, BASE);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " blocks"}, 32'(blocks), 32'd0);
    endtask

    task automatic clear_session();
        sent_q.delete();
        exp_q.delete();
        cap_q.delete();
        blk_addr_q.delete();
        wr_cnt   = 0;
        done_cnt = 0;
        acc_cnt  = 0;
        cons_cnt = 0;
        card_idx = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done seen"}, 32'(done), 32'd1);
        chk({tag, " busy low with done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, " done pulse count"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic feed_and_flush(input string tag);
        int n;
        n = 0;
        foreach (sent_q[i]) prod_q.push_back(sent_q[i]);
        while (prod_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " producer drained"}, 32'(prod_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(tag);
    endtask

    // Reference: whole blocks in order; a trailing partial block is padded or dropped.
    task automatic build_exp(output int nblk);
        int full;
        full = (sent_q.size() / BB) * BB;
        exp_q.delete();
        for (int i = 0; i < full; i++) exp_q.push_back(sent_q[i]);
        nblk = full / BB;
`ifdef SD_BLOCK_WRITER_PAD_EN
        if (sent_q.size() > full) begin
            for (int i = full; i < sent_q.size(); i++) exp_q.push_back(sent_q[i]);
            for (int i = sent_q.size(); i < full + BB; i++) exp_q.push_back(PAD);
            nblk++;
        end
`endif
    endtask

    task automatic check_blocks(input string tag, input int nblk);
        int mism;
        int lim;
        chk({tag, " wr pulses"}, 32'(wr_cnt), 32'(nblk));
        chk({tag, " bytes captured"}, 32'(cap_q.size()), 32'(exp_q.size()));
        mism = 0;
        lim  = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) if (cap_q[i] !== exp_q[i]) mism++;
        chk({tag, " byte mismatches"}, 32'(mism), 32'd0);
        for (int b = 0; b < blk_addr_q.size(); b++)
            chk($sformatf("%s addr blk%0d", tag, b), blk_addr_q[b], BASE + 32'(b * BB));
        chk({tag, " blocks_written"}, 32'(blocks), 32'(nblk));
    endtask

    initial begin : main
        int nblk;
        int n;
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: one full block of 0..255,0..255, with a held request mid-block.
        clear_session();
        for (int i = 0; i < BB; i++) sent_q.push_back(8'(i));
        hold_at = 100;
        start = 1'b1;
        @(negedge clk);
        chk("t1 ready after start", 32'(data_ready), 32'd1);
        chk("t1 busy after start", 32'(busy), 32'd1);
        start = 1'b0;
        feed_and_flush("t1");
        build_exp(nblk);
        check_blocks("t1", nblk);
        chk("t1 held request advances one entry", 32'(hold_din), 32'd101);
        hold_at = -1;

        // 2: three blocks back to back with the FIFO running full.
        clear_session();
        prod_rand    = 1'b0;
        card_gap_max = 4;
        stall_cnt    = 0;
        for (int i = 0; i < 3 * BB; i++) sent_q.push_back(8'($urandom));
        pulse_start();
        feed_and_flush("t2");
        build_exp(nblk);
        check_blocks("t2", nblk);
        chk("t2 ready dropped while full", 32'(stall_cnt > 0), 32'd1);
        prod_rand    = 1'b1;
        card_gap_max = 2;

        // 3: short session of 100 bytes.
        clear_session();
        for (int i = 0; i < 100; i++) sent_q.push_back(8'($urandom));
        pulse_start();
        feed_and_flush("t3");
        build_exp(nblk);
        check_blocks("t3", nblk);

        // 4: stop at byte 300 with 50 bytes behind the block; starts are ignored.
        clear_session();
        for (int i = 0; i < BB + 50; i++) sent_q.push_back(8'($urandom));
        pulse_start();
        foreach (sent_q[i]) prod_q.push_back(sent_q[i]);
        n = 0;
        while (card_idx < 300 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("t4 reached byte 300", 32'(card_idx >= 300), 32'd1);
        chk("t4 all bytes queued", 32'(prod_q.size()), 32'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) begin
            repeat (20) @(negedge clk);
            pulse_start();
        end
        wait_done("t4");
        build_exp(nblk);
        check_blocks("t4", nblk);

        // 5: asynchronous reset at byte 200, then a clean session.
        clear_session();
        for (int i = 0; i < 600; i++) sent_q.push_back(8'($urandom));
        pulse_start();
        foreach (sent_q[i]) prod_q.push_back(sent_q[i]);
        n = 0;
        while (card_idx < 200 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("t5 reached byte 200", 32'(card_idx >= 200), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_values("t5 async reset");
        prod_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while ((sd_ready !== 1'b1 || rfnb !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        clear_session();
        for (int i = 0; i < BB; i++) sent_q.push_back(8'($urandom));
        pulse_start();
        feed_and_flush("t5");
        build_exp(nblk);
        check_blocks("t5", nblk);

        chk("wr never high two cycles", 32'(wr_double), 32'd0);
        chk("ready only dropped when full or stopped", 32'(stall_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
